// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//
// Arbitrates single-register read and write requests for the external RTC
// chip and sequences one multiplexed address/data bus cycle per accepted
// request. Each bus cycle has three address phases (setup, strobe, hold) and
// three data phases (setup, strobe, hold), each T_PH clocks long. A single
// DONE cycle follows, in which the owner's ack pulses.
//
// Handshake: a requester raises *_req (a level) with address/data stable and
// holds it until its *_ack pulse. The sequencer only samples requests in IDLE.
// Acceptance happens on the clock edge that leaves IDLE. A request that is
// withdrawn after acceptance still completes and still acks. To get exactly
// one transaction, the requester drops *_req on the edge that ends the ack
// cycle.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   rd_req/rd_addr    read request level and register address
//   rd_ack/rd_data    read completion pulse and captured data
//   wr_req/wr_addr/   write request level, register address and data
//   wr_data
//   wr_ack            write completion pulse
//   busy              high from the cycle after acceptance through DONE
//   grant             current or last owner (0 = read, 1 = write)
//   dato              multiplexed RTC bus; high-Z unless driving
//   a_d               0 = address phase, 1 = data phase
//   cs, rd, wr        active-low chip select, read strobe, write/addr strobe
//   dbg_state         current FSM state, for observation only
//
// All pin-facing outputs, including the bus output enable, come straight
// from flops. Their next values are derived from the next state, so every
// pin changes together with the state register.

module rtc_bus_sequencer #(
  parameter int T_PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       grant,
  inout  wire  [7:0] dato,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_SU  = 3'd1,
    S_A_STB = 3'd2,
    S_A_HLD = 3'd3,
    S_D_SU  = 3'd4,
    S_D_STB = 3'd5,
    S_D_HLD = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(T_PH - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       owner_q, owner_d;   // 1 = write owns the bus
  logic       last_q, last_d;     // 1 = write was served last
  logic [7:0] rd_data_q, rd_data_d;

  // Registered pin drivers.
  logic       a_d_q, a_d_d;
  logic       cs_q, cs_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;
  logic       rd_ack_q, rd_ack_d;
  logic       wr_ack_q, wr_ack_d;
  logic       busy_q, busy_d;

  logic       phase_end;
  logic       pick_wr;
  logic       a_ph_d;
  logic       d_ph_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_data_d = rd_data_q;
    phase_end = (cnt_q == CNT_LAST);
    // On a tie the requester that was not served last wins.
    pick_wr   = wr_req && (!rd_req || !last_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_req || wr_req) begin
          owner_d = pick_wr;
          addr_d  = pick_wr ? wr_addr : rd_addr;
          data_d  = pick_wr ? wr_data : data_q;
          state_d = S_A_SU;
        end
      end
      S_A_SU, S_A_STB, S_A_HLD, S_D_SU, S_D_STB, S_D_HLD: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = state_t'(state_q + 3'd1);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        // Capture on the last strobe cycle, while rd is still low and the
        // chip has had the whole strobe phase to drive the bus.
        if (state_q == S_D_STB && phase_end && !owner_q) begin
          rd_data_d = dato;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    a_ph_d   = (state_d == S_A_SU) || (state_d == S_A_STB) || (state_d == S_A_HLD);
    d_ph_d   = (state_d == S_D_SU) || (state_d == S_D_STB) || (state_d == S_D_HLD);
    a_d_d    = !a_ph_d;
    cs_d     = !((state_d == S_A_STB) || (state_d == S_D_STB));
    wr_d     = !((state_d == S_A_STB) || ((state_d == S_D_STB) && owner_d));
    rd_d     = !((state_d == S_D_STB) && !owner_d);
    oe_d     = a_ph_d || (d_ph_d && owner_d);
    dout_d   = a_ph_d ? addr_d : data_d;
    rd_ack_d = (state_d == S_DONE) && !owner_d;
    wr_ack_d = (state_d == S_DONE) && owner_d;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      rd_data_q <= '0;
      a_d_q     <= 1'b1;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_data_q <= rd_data_d;
      a_d_q     <= a_d_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign dato      = oe_q ? dout_q : {8{1'bz}};
  assign a_d       = a_d_q;
  assign cs        = cs_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign rd_ack    = rd_ack_q;
  assign wr_ack    = wr_ack_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign grant     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: one instance with T_PH=4 and one with T_PH=1.
// Each instance has its own bus with a pull-up (so an undriven bus reads 0xFF)
// and a chip model that drives a fixed byte while rd is low.

module tb_rtc_bus_sequencer;

  localparam int W = 26;  // {inst, is_wr, addr[8], data[8], latency[8]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic       rd_req  [2];
  logic       wr_req  [2];
  logic [7:0] rd_addr [2];
  logic [7:0] wr_addr [2];
  logic [7:0] wr_data [2];
  logic [7:0] bus_val [2];

  wire [1:0] ack_v;
  wire [1:0] cs_v;
  wire [1:0] ad_v;
  wire [1:0] wr_v;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h", g, name, act, exp);
    end
  endtask

  // ---------------- DUT instances + monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TP = (g == 0) ? 4 : 1;
    wire  [7:0] dato;
    logic       rd_ack, wr_ack, busy, grant, a_d, cs, rd, wr;
    logic [7:0] rd_data;
    logic [2:0] dbg_state;

    for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup pu (dato[b]);
    end
    assign dato = (rd == 1'b0) ? bus_val[g] : 8'hzz;

    assign ack_v[g] = rd_ack | wr_ack;
    assign cs_v[g]  = cs;
    assign ad_v[g]  = a_d;
    assign wr_v[g]  = wr;

    rtc_bus_sequencer #(.T_PH(TP)) u_dut (
      .clk      (clk),
      .reset    (reset_n),
      .rd_req   (rd_req[g]),
      .rd_addr  (rd_addr[g]),
      .rd_ack   (rd_ack),
      .rd_data  (rd_data),
      .wr_req   (wr_req[g]),
      .wr_addr  (wr_addr[g]),
      .wr_data  (wr_data[g]),
      .wr_ack   (wr_ack),
      .busy     (busy),
      .grant    (grant),
      .dato     (dato),
      .a_d      (a_d),
      .cs       (cs),
      .rd       (rd),
      .wr       (wr),
      .dbg_state(dbg_state)
    );

    int busy_cnt, ad0, cs_lo, rd_lo, wr_lo, addr_bad, data_bad;
    logic         have_cur;
    logic [W-1:0] cur;
    logic [W-1:0] e;

    always @(negedge clk) begin
      if (!reset_n) begin
        busy_cnt = 0; ad0 = 0; cs_lo = 0; rd_lo = 0; wr_lo = 0;
        addr_bad = 0; data_bad = 0; have_cur = 1'b0;
      end else begin
        checks++;
        if (!rd && !wr) begin
          errors++;
          $display("FAIL inst%0d strobe_overlap: rd=%b wr=%b, required not both 0", g, rd, wr);
        end
        if (busy) begin
          busy_cnt++;
          if (busy_cnt == 1) begin
            have_cur = (exp_q.size() > 0) && (exp_q[0][25] == 1'(g));
            if (have_cur) cur = exp_q[0];
          end
          if (!a_d) begin
            ad0++;
            if (have_cur && dato != cur[23:16]) addr_bad++;
          end else if (!(rd_ack || wr_ack)) begin
            if (have_cur) begin
              if (cur[24]) begin
                if (dato != cur[15:8]) data_bad++;
              end else if (rd && dato != 8'hff) begin
                data_bad++;
              end
            end
          end else if (dato != 8'hff) begin
            data_bad++;
          end
          if (!cs) cs_lo++;
          if (!rd) rd_lo++;
          if (!wr) wr_lo++;
        end
        if (rd_ack || wr_ack) begin
          if (!have_cur) begin
            checks++;
            errors++;
            $display("FAIL inst%0d unexpected_ack: rd_ack=%b wr_ack=%b, required no ack", g, rd_ack, wr_ack);
          end else begin
            e = exp_q.pop_front();
            chk("ack_kind", g, {30'd0, rd_ack, wr_ack}, e[24] ? 1 : 2);
            chk("grant", g, int'(grant), int'(e[24]));
            chk("latency", g, busy_cnt, int'(e[7:0]));
            chk("addr_phase_cycles", g, ad0, 3 * TP);
            chk("cs_low_cycles", g, cs_lo, 2 * TP);
            chk("rd_low_cycles", g, rd_lo, e[24] ? 0 : TP);
            chk("wr_low_cycles", g, wr_lo, e[24] ? 2 * TP : TP);
            chk("addr_on_bus_errs", g, addr_bad, 0);
            chk("data_on_bus_errs", g, data_bad, 0);
            if (!e[24]) chk("rd_data", g, int'(rd_data), int'(e[15:8]));
          end
          busy_cnt = 0; ad0 = 0; cs_lo = 0; rd_lo = 0; wr_lo = 0;
          addr_bad = 0; data_bad = 0; have_cur = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input int g, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!ack_v[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ack_arrived", g, int'(ack_v[g]), 1);
  endtask

  task automatic wait_astb(input int g);
    int n;
    n = 0;
    @(negedge clk);
    while (!(cs_v[g] == 1'b0 && ad_v[g] == 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_a_stb", g, int'(!cs_v[g] && !ad_v[g]), 1);
  endtask

  task automatic single(input int g, input bit is_wr, input logic [7:0] addr,
                        input logic [7:0] data, input logic [7:0] lat, input bit drop);
    exp_q.push_back({1'(g), is_wr, addr, data, lat});
    @(posedge clk);
    #1;
    if (is_wr) begin
      wr_addr[g] = addr; wr_data[g] = data; wr_req[g] = 1'b1;
    end else begin
      rd_addr[g] = addr; rd_req[g] = 1'b1;
    end
    if (drop) begin
      wait_astb(g);
      if (is_wr) wr_req[g] = 1'b0;
      else       rd_req[g] = 1'b0;
    end
    wait_ack(g, 200);
    @(posedge clk);
    #1;
    rd_req[g] = 1'b0;
    wr_req[g] = 1'b0;
  endtask

  task automatic check_idle_pins(input string tag);
    chk({tag, "_cs"},      0, int'(g_dut[0].cs), 1);
    chk({tag, "_wr"},      0, int'(g_dut[0].wr), 1);
    chk({tag, "_rd"},      0, int'(g_dut[0].rd), 1);
    chk({tag, "_a_d"},     0, int'(g_dut[0].a_d), 1);
    chk({tag, "_dato_z"},  0, int'(g_dut[0].dato), 8'hff);
    chk({tag, "_busy"},    0, int'(g_dut[0].busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prev;
    for (int g = 0; g < 2; g++) begin
      rd_req[g] = 1'b0; wr_req[g] = 1'b0;
      rd_addr[g] = '0; wr_addr[g] = '0; wr_data[g] = '0;
    end
    bus_val[0] = 8'h37;
    bus_val[1] = 8'h5a;
    reset_n = 1'b0;

    // Reset held with random request activity.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        rd_req[g]  = 1'($urandom_range(0, 1));
        wr_req[g]  = 1'($urandom_range(0, 1));
        rd_addr[g] = 8'($urandom_range(0, 255));
        wr_addr[g] = 8'($urandom_range(0, 255));
        wr_data[g] = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      check_idle_pins("reset");
      chk("reset_rd_ack",  0, int'(g_dut[0].rd_ack), 0);
      chk("reset_wr_ack",  0, int'(g_dut[0].wr_ack), 0);
      chk("reset_rd_data", 0, int'(g_dut[0].rd_data), 0);
      chk("reset_grant",   0, int'(g_dut[0].grant), 0);
      chk("reset_busy",    1, int'(g_dut[1].busy), 0);
      chk("reset_cs",      1, int'(g_dut[1].cs), 1);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      rd_req[g] = 1'b0; wr_req[g] = 1'b0;
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single write and single read, T_PH=4.
    single(0, 1'b1, 8'h21, 8'h45, 8'd25, 1'b0);
    single(0, 1'b0, 8'h22, 8'h37, 8'd25, 1'b0);

    // Both requests held: W, R, W, R, acks 26 cycles apart.
    exp_q.push_back({1'b0, 1'b1, 8'h31, 8'h46, 8'd25});
    exp_q.push_back({1'b0, 1'b0, 8'h32, 8'h37, 8'd25});
    exp_q.push_back({1'b0, 1'b1, 8'h31, 8'h46, 8'd25});
    exp_q.push_back({1'b0, 1'b0, 8'h32, 8'h37, 8'd25});
    @(posedge clk);
    #1;
    rd_addr[0] = 8'h32; wr_addr[0] = 8'h31; wr_data[0] = 8'h46;
    rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 200);
      if (k > 0) chk("ack_spacing", 0, cyc - prev, 26);
      prev = cyc;
    end
    @(posedge clk);
    #1;
    rd_req[0] = 1'b0; wr_req[0] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during the data strobe of a write.
    @(posedge clk);
    #1;
    wr_addr[0] = 8'h41; wr_data[0] = 8'h99; wr_req[0] = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(ad_v[0] == 1'b1 && wr_v[0] == 1'b0) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("reached_d_stb", 0, int'(ad_v[0] && !wr_v[0]), 1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_pins("abort");
    wr_req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_pins("after_abort");
    single(0, 1'b1, 8'h42, 8'h55, 8'd25, 1'b0);

    // Request withdrawn during the address strobe, T_PH=4 and T_PH=1.
    single(0, 1'b0, 8'h23, 8'h37, 8'd25, 1'b1);
    single(1, 1'b0, 8'h24, 8'h5a, 8'd7, 1'b1);
    single(1, 1'b1, 8'h25, 8'h66, 8'd7, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_empty", 0, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Arbiter and bus-cycle sequencer for the multiplexed address/data bus of the external RTC chip. It accepts single-register read requests (periodic time/date scan) and write requests (user edits, alarm/timer configuration). It grants the bus to one requester at a time and generates the address-phase/data-phase strobe sequence on `a_d`, `cs`, `rd`, `wr` and `dato`. It sits between the RTC control logic and the chip pins, replacing ad-hoc strobe generation in the control FSM.

## Interface

- `T_PH`, default 4: clock cycles per bus phase; legal range 1..15.

- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rd_req` in 1: read request; level, held until `rd_ack`.
- `rd_addr` in 8: RTC register address for the read; stable while `rd_req`=1.
- `rd_ack` out 1: one-cycle pulse when the read completes.
- `rd_data` out 8: captured read data; valid from `rd_ack` until the next read completes.
- `wr_req` in 1: write request; level, held until `wr_ack`.
- `wr_addr` in 8: RTC register address for the write.
- `wr_data` in 8: data to write; stable while `wr_req`=1.
- `wr_ack` out 1: one-cycle pulse when the write completes.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle.
- `grant` out 1: current or last owner; 0=read, 1=write.
- `dato` inout 8: RTC multiplexed bus; high-Z unless driving.
- `a_d` out 1: 0 = address phase, 1 = data phase.
- `cs` out 1: chip select, active-low.
- `rd` out 1: read strobe, active-low.
- `wr` out 1: write/address strobe, active-low.

## Operation

- States: IDLE, A_SU, A_STB, A_HLD, D_SU, D_STB, D_HLD, DONE.
- Phase counter `cnt` runs 0..T_PH-1 in each phase state. The state advances when `cnt`=T_PH-1, and `cnt` clears on each advance.
- IDLE: samples `rd_req` and `wr_req`.
  - Only one request high: that requester is accepted.
  - Both high: round-robin; the requester not served last wins. After reset, last-served = read, so write wins the first tie.
  - On acceptance: latch address, write data and owner into internal registers; set `grant`; go to A_SU.
  - Requester inputs are ignored outside IDLE.
- A_SU / A_STB / A_HLD:
  - `a_d`=0.
  - `dato` is driven with the latched address.
  - `cs`=0 and `wr`=0 only in A_STB.
- D_SU / D_STB / D_HLD:
  - `a_d`=1.
  - Write: `dato` is driven with the latched data; `cs`=0 and `wr`=0 only in D_STB.
  - Read: `dato` is high-Z; `cs`=0 and `rd`=0 only in D_STB. `rd_data` is loaded from `dato` on the last D_STB cycle (`cnt`=T_PH-1).
- DONE: one cycle.
  - The owner's ack = 1 and the last-served register is updated.
  - All strobes are high and `dato` is high-Z.
  - The next state is always IDLE.
- A request dropped mid-transaction does not abort it; the ack is still pulsed.
- `rd` and `wr` are never both low.
- `cs` is never low in a setup or hold phase.

## Timing

- Reset values (asynchronous, immediate while `reset`=0):
  - `a_d`=1, `cs`=1, `rd`=1, `wr`=1.
  - `dato`=Z, `rd_ack`=0, `wr_ack`=0, `rd_data`=0x00, `busy`=0, `grant`=0.
  - State = IDLE, `cnt`=0, last-served = read.
- Reset asserted mid-transaction releases the bus in the same instant and produces no ack. The transaction is lost and the requester must re-request.
- Latency: the request is accepted on edge E0. The state sits in A_SU for the cycles after E0, and the ack is high during cycle E0+6·T_PH+1. With T_PH=4, the ack falls in cycle 25 after acceptance.
- IDLE lasts at least one cycle between transactions, so back-to-back throughput is 6·T_PH+2 cycles per transaction.
- Handshake: a requester wanting exactly one transaction deasserts `req` on the edge ending the ack cycle. IDLE samples on the following edge, so no duplicate is issued.
- Registered outputs: all strobes, `a_d`, the `dato` enable and the acks are flop outputs, so pins carry no combinational glitches.

## Test plan

- Reset: hold `reset`=0 with random requests → strobes all 1, `dato`=Z, acks 0, `rd_data`=0x00, `busy`=0.
- Single write, T_PH=4, `wr_addr`=0x21, `wr_data`=0x45:
  - `dato`=0x21 with `a_d`=0 for 12 cycles; `cs`/`wr` low for 4 cycles in the middle.
  - Then `dato`=0x45 with `a_d`=1; `wr` low for 4 cycles.
  - `wr_ack` pulses at cycle 25; `rd` stays 1 throughout.
- Single read, `rd_addr`=0x22, bus model drives 0x37 while `rd`=0 → `dato` is Z during data phases, `rd_data`=0x37, `rd_ack` pulses at cycle 25, `wr` stays 1 in the data phase.
- Both requests held continuously from reset → order W, R, W, R; each ack spaced 26 cycles apart; `grant` toggles.
- Assert `reset` during D_STB of a write → `cs`=`wr`=1 and `dato`=Z within the same cycle, no `wr_ack`; after release, state is IDLE and a new request completes normally.
- Drop `rd_req` during A_STB; also test T_PH=1 → transaction completes, `rd_ack` still pulses; with T_PH=1 the ack comes at cycle 7.
